// File: rtl/acc_pkg.sv
// Shared types and default widths for the
// product accumulator datapath.
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 12;

endpackage

// File: rtl/sat_adder.sv
// Unsigned W-bit adder that clamps to all-ones
// and flags when the true sum does not fit.
module sat_adder #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    sat  = full[W];
    sum  = full[W] ? '1 : full[W-1:0];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT products per result into a saturating
// accumulator and hands the total downstream.
module product_accumulator #(
  parameter int PROD_W = acc_pkg::PROD_W,
  parameter int ACC_W  = acc_pkg::ACC_W,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PROD_W-1:0] product,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              busy
);

  import acc_pkg::*;

  localparam int CNT_W = $clog2(COUNT + 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   add_sum;
  logic               add_sat;
  logic [CNT_W-1:0]   cnt_inc;

  sat_adder #(.W(ACC_W)) u_add (
    .a   (acc_q),
    .b   (ACC_W'(product)),
    .sum (add_sum),
    .sat (add_sat)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      (state_q == ACCUM): begin
        if (in_valid) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_sat;
          if (cnt_inc == CNT_W'(COUNT))
            state_d = DONE;
        end
      end
      (state_q == DONE): begin
        // start only counts once the result is taken
        if (out_ready) begin
          if (start) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

endmodule
